func_test_seq: RTL

- Parametrised successor to the functional-test sequencer for the SBIS BOS video front end, built on one clock.
- Loads a pattern of DAC samples from the PC byte stream, then replays it to the DAC a configurable number of times. Replay can run in CCD mode (black level and video interleaved) or plain-ADC mode.
- Generates CLK/SHP/SHD pixel timing with a parametrised pixel period, captures ADC words, and returns them to the PC as a byte stream.

---
 rtl/func_test_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/func_test_seq.sv
// Functional-test sequencer: loads a DAC pattern from the PC byte stream, replays it
// with CLK/SHP/SHD pixel timing, captures ADC words and returns them as a byte stream.
module func_test_seq #(
  parameter int DAC_W  = 14,
  parameter int ADC_W  = 12,
  parameter int PAT_AW = 9,
  parameter int CAP_AW = 9,
  parameter int PERIOD = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [7:0]       master_data,
  input  logic             ctrl_ena,
  input  logic             samples_ena,
  input  logic             black_ena,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_fpga,
  output logic             shp_fpga,
  output logic             shd_fpga,
  input  logic [ADC_W-1:0] q_fpga,
  input  logic             q_valid,
  input  logic             rd_req,
  output logic [7:0]       rd_data,
  output logic             have_msg,
  output logic [15:0]      len,
  output logic [1:0]       state_o,
  output logic [2:0]       err_o
);
  localparam int PH_W      = $clog2(PERIOD);
  localparam int PAT_DEPTH = 1 << PAT_AW;
  localparam int CAP_DEPTH = 1 << CAP_AW;

  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(PERIOD / 2);
  localparam logic [PH_W-1:0]   PH_HALF1 = PH_W'(PERIOD / 2 + 1);
  localparam logic [PH_W-1:0]   PH_Q1    = PH_W'(PERIOD / 4);
  localparam logic [PH_W-1:0]   PH_Q3    = PH_W'(3 * PERIOD / 4);
  localparam logic [PAT_AW:0]   PAT_ONE  = (PAT_AW+1)'(1);
  localparam logic [PAT_AW:0]   PAT_FULL = (PAT_AW+1)'(PAT_DEPTH);
  localparam logic [CAP_AW:0]   CAP_ONE  = (CAP_AW+1)'(1);
  localparam logic [CAP_AW:0]   CAP_FULL = (CAP_AW+1)'(CAP_DEPTH);
  localparam logic [CAP_AW+1:0] B_ONE    = (CAP_AW+2)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, DUMP = 2'd3} state_t;
  typedef struct packed {
    logic start;
    logic stop;
    logic abort;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd;

  logic [15:0]       black;
  logic [DAC_W-1:0]  pat_mem [PAT_DEPTH];
  logic [ADC_W-1:0]  cap_mem [CAP_DEPTH];
  logic [PAT_AW:0]   pat_cnt;
  logic [PAT_AW-1:0] pat_idx;
  logic [CAP_AW:0]   cap_cnt, cap_rd;
  logic [CAP_AW+1:0] bytes_left;
  logic [PH_W-1:0]   phase;
  logic [7:0]        lsb_byte;
  logic [3:0]        loops;
  logic [DAC_W-1:0]  pat_rd;
  logic [15:0]       cap_word;
  logic              lsb_vld, byte_sel, mode;
  logic              pix_end, idx_wrap, last_pix, play_on, pop;
  logic              sample_in, pat_we, cap_in, cap_we;

  // Abort is checked first everywhere; its code cannot collide with start/stop anyway.
  always_comb begin
    cmd.abort = ctrl_ena && (master_data == 8'hFF);
    cmd.start = ctrl_ena && (master_data[7:4] == 4'hA) && (state == IDLE);
    cmd.stop  = ctrl_ena && (master_data == 8'h55) && (state == LOAD);
  end

  assign pix_end    = (phase == PH_LAST);
  assign idx_wrap   = ({1'b0, pat_idx} == pat_cnt - PAT_ONE);
  assign last_pix   = pix_end && idx_wrap && (loops == 4'd1);
  assign bytes_left = {cap_cnt - cap_rd, 1'b0} - (CAP_AW+2)'(byte_sel);
  assign pop        = (state == DUMP) && rd_req && (bytes_left != '0);
  assign sample_in  = (state == LOAD) && samples_ena && !ctrl_ena;
  assign pat_we     = sample_in && lsb_vld && (pat_cnt != PAT_FULL);
  assign cap_in     = (state == PLAY) && q_valid && !cmd.abort;
  assign cap_we     = cap_in && (cap_cnt != CAP_FULL);
  assign play_on    = (state == PLAY) && (state_nxt == PLAY);
  assign pat_rd     = pat_mem[pat_idx];
  assign cap_word   = 16'(cap_mem[cap_rd[CAP_AW-1:0]]);

  // FSM: state register
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (cmd.abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (cmd.start) state_nxt = LOAD;
        LOAD: if (cmd.stop) state_nxt = (pat_cnt == '0) ? IDLE : PLAY;
        PLAY: if (last_pix) state_nxt = DUMP;
        DUMP: if ((bytes_left == '0) || (pop && (bytes_left == B_ONE))) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state_o  = state;
    have_msg = (state == DUMP) && (bytes_left != '0);
    len      = (state == DUMP) ? 16'(bytes_left) : 16'h0000;
  end

  always_ff @(posedge sys_clk) begin
    if (pat_we) pat_mem[pat_cnt[PAT_AW-1:0]] <= DAC_W'({master_data, lsb_byte});
    if (cap_we) cap_mem[cap_cnt[CAP_AW-1:0]] <= q_fpga;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      black    <= '0;
      mode     <= 1'b0;
      loops    <= '0;
      err_o    <= '0;
      pat_cnt  <= '0;
      pat_idx  <= '0;
      lsb_vld  <= 1'b0;
      lsb_byte <= '0;
      cap_cnt  <= '0;
      cap_rd   <= '0;
      byte_sel <= 1'b0;
      rd_data  <= '0;
      phase    <= '0;
      dac_d    <= '0;
      clk_fpga <= 1'b1;
      shp_fpga <= 1'b1;
      shd_fpga <= 1'b1;
    end else begin
      if (black_ena) black <= {master_data, black[15:8]};

      if (cmd.abort) begin
        pat_cnt  <= '0;
        cap_cnt  <= '0;
        cap_rd   <= '0;
        byte_sel <= 1'b0;
        lsb_vld  <= 1'b0;
      end else if (cmd.start) begin
        mode     <= master_data[0];
        loops    <= {1'b0, master_data[3:1]} + 4'd1;
        err_o    <= '0;
        pat_cnt  <= '0;
        cap_cnt  <= '0;
        cap_rd   <= '0;
        byte_sel <= 1'b0;
        lsb_vld  <= 1'b0;
      end else if (cmd.stop) begin
        lsb_vld <= 1'b0;
        pat_idx <= '0;
        if (pat_cnt == '0) err_o[2] <= 1'b1;
      end else begin
        // Pattern bytes pair LSB first; the word lands on the second byte.
        if (sample_in) begin
          lsb_vld <= !lsb_vld;
          if (!lsb_vld)                lsb_byte <= master_data;
          else if (pat_cnt == PAT_FULL) err_o[0] <= 1'b1;
          else                          pat_cnt  <= pat_cnt + PAT_ONE;
        end
        if (cap_in) begin
          if (cap_cnt == CAP_FULL) err_o[1] <= 1'b1;
          else                     cap_cnt  <= cap_cnt + CAP_ONE;
        end
        if (play_on && pix_end) begin
          if (idx_wrap) begin
            pat_idx <= '0;
            loops   <= loops - 4'd1;
          end else begin
            pat_idx <= pat_idx + 1'b1;
          end
        end
        if (pop) begin
          rd_data  <= byte_sel ? cap_word[15:8] : cap_word[7:0];
          byte_sel <= !byte_sel;
          if (byte_sel) cap_rd <= cap_rd + CAP_ONE;
        end
      end

      // Pixel timing: strobes forced high whenever the next cycle is not PLAY.
      phase <= play_on ? phase + PH_ONE : '0;
      if (play_on) begin
        clk_fpga <= (phase < PH_HALF);
        shp_fpga <= !((phase >= PH_ONE) && (phase <= PH_Q1));
        shd_fpga <= !((phase >= PH_HALF1) && (phase <= PH_Q3));
        if (!mode)                 dac_d <= pat_rd;
        else if (phase == '0)      dac_d <= black[DAC_W-1:0];
        else if (phase == PH_HALF) dac_d <= pat_rd;
      end else begin
        clk_fpga <= 1'b1;
        shp_fpga <= 1'b1;
        shd_fpga <= 1'b1;
      end
    end
  end
endmodule
